// File: rtl/game_timer.sv
// Countdown game timer: MM:SS held as four BCD digits, decremented once per
// TICK_DIV clock cycles while running, with pause/resume, +10 s bonus and
// restart. On expiry the digits spell "End" in the seven-segment decoder's
// letter codes and timeUp pulses for one cycle.
module game_timer #(
   parameter int TICK_DIV  = 50_000_000,
   parameter int START_MIN = 3,
   parameter int START_SEC = 0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       pause,
   input  logic       restart,
   input  logic       addTime,
   output logic [3:0] digit3,
   output logic [3:0] digit2,
   output logic [3:0] digit1,
   output logic [3:0] digit0,
   output logic       running,
   output logic       expired,
   output logic       timeUp
);

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

   // Decoder letter codes used for the "End" message.
   localparam logic [3:0] CODE_E     = 4'd13;
   localparam logic [3:0] CODE_N     = 4'd14;
   localparam logic [3:0] CODE_D     = 4'd12;
   localparam logic [3:0] CODE_BLANK = 4'd15;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_PAUSE = 2'd2,
      S_DONE  = 2'd3
   } state_e;

   typedef struct packed {
      logic [3:0] mt;  // minutes tens, 0..9
      logic [3:0] mo;  // minutes ones, 0..9
      logic [3:0] st;  // seconds tens, 0..5
      logic [3:0] so;  // seconds ones, 0..9
   } bcd_time_t;

   localparam bcd_time_t PRESET = '{
      mt: 4'(START_MIN / 10),
      mo: 4'(START_MIN % 10),
      st: 4'(START_SEC / 10),
      so: 4'(START_SEC % 10)
   };

   localparam bcd_time_t TIME_MAX = '{mt: 4'd9, mo: 4'd9, st: 4'd5, so: 4'd9};

   // One-second BCD decrement with borrow ripple; never called on 00:00.
   function automatic bcd_time_t dec_time(input bcd_time_t t);
      bcd_time_t r;
      r = t;
      if (t.so != 4'd0) begin
         r.so = t.so - 4'd1;
      end else begin
         r.so = 4'd9;
         if (t.st != 4'd0) begin
            r.st = t.st - 4'd1;
         end else begin
            r.st = 4'd5;
            if (t.mo != 4'd0) begin
               r.mo = t.mo - 4'd1;
            end else begin
               r.mo = 4'd9;
               r.mt = t.mt - 4'd1;
            end
         end
      end
      return r;
   endfunction

   // Ten-second BCD increment with carry into minutes, saturating at 99:59.
   function automatic bcd_time_t add10_time(input bcd_time_t t);
      bcd_time_t r;
      r = t;
      if (t.mt == 4'd9 && t.mo == 4'd9 && t.st == 4'd5) begin
         r = TIME_MAX;
      end else if (t.st != 4'd5) begin
         r.st = t.st + 4'd1;
      end else begin
         r.st = 4'd0;
         if (t.mo != 4'd9) begin
            r.mo = t.mo + 4'd1;
         end else begin
            r.mo = 4'd0;
            r.mt = t.mt + 4'd1;
         end
      end
      return r;
   endfunction

   state_e          state_q, state_d;
   bcd_time_t       time_q, time_d;
   bcd_time_t       time_work;
   logic [PW-1:0]   presc_q, presc_d;
   logic            timeup_q, timeup_d;
   logic            tick;
   logic            add_en;
   logic            expire_hit;

   assign tick   = (state_q == S_RUN) && (presc_q == PRESC_MAX);
   assign add_en = addTime && ((state_q == S_RUN) || (state_q == S_PAUSE));

   // Time and prescaler next-state: decrement first, then bonus, so that a
   // coinciding tick and addTime net +9 s with saturation on the sum.
   always_comb begin
      // NOTE: every variable gets a default before any branch so no latch is inferred.
      time_work = time_q;
      time_d    = time_q;
      presc_d   = presc_q;
      if (restart) begin
         time_d  = PRESET;
         presc_d = '0;
      end else begin
         if (tick) begin
            time_work = dec_time(time_work);
         end
         if (add_en) begin
            time_work = add10_time(time_work);
         end
         time_d = time_work;
         if (state_q == S_RUN) begin
            presc_d = tick ? '0 : presc_q + PW'(1);
         end else if (state_q == S_IDLE && start) begin
            presc_d = '0;
         end
      end
   end

   // Expiry is judged on the net result of this cycle's tick and bonus.
   assign expire_hit = tick && (time_d == '0);

   // FSM next-state logic; restart outranks pause, which outranks start.
   always_comb begin
      state_d = state_q;
      if (restart) begin
         state_d = S_IDLE;
      end else begin
         unique case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN: begin
               if (expire_hit)  state_d = S_DONE;
               else if (pause)  state_d = S_PAUSE;
            end
            S_PAUSE: if (pause || start) state_d = S_RUN;
            S_DONE:  state_d = S_DONE;
            default: state_d = S_IDLE;
         endcase
      end
   end

   // timeUp fires only on the transition into DONE.
   assign timeup_d = (state_d == S_DONE) && (state_q != S_DONE);

   // State, time, prescaler and timeUp registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         time_q   <= PRESET;
         presc_q  <= '0;
         timeup_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state_q  <= state_d;
         time_q   <= time_d;
         presc_q  <= presc_d;
         timeup_q <= timeup_d;
      end
   end

   // Output decode of registered state: digits, running and expired.
   always_comb begin
      running = (state_q == S_RUN);
      expired = (state_q == S_DONE);
      if (state_q == S_DONE) begin
         digit3 = CODE_E;
         digit2 = CODE_N;
         digit1 = CODE_D;
         digit0 = CODE_BLANK;
      end else begin
         digit3 = time_q.mt;
         digit2 = time_q.mo;
         digit1 = time_q.st;
         digit0 = time_q.so;
      end
   end

   assign timeUp = timeup_q;

endmodule

// File: tb/tb_game_timer.sv
// Directed bench for game_timer. Four instances with different presets
// cover expiry, borrow chain, pause retention, bonus time, priority and
// asynchronous reset. Inputs change and outputs are sampled on negedge.
module tb_game_timer;

   logic clk;
   logic [3:0] rstn_v;
   logic [3:0] start_v;
   logic [3:0] pause_v;
   logic [3:0] restart_v;
   logic [3:0] add_v;

   wire [63:0] dig_all;
   wire [3:0]  run_all;
   wire [3:0]  exp_all;
   wire [3:0]  tup_all;

   int checks;
   int failures;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // A: fast tick, 00:03 preset
   game_timer #(.TICK_DIV(4), .START_MIN(0), .START_SEC(3)) u_a (
      .clk(clk), .rst_n(rstn_v[0]), .start(start_v[0]), .pause(pause_v[0]),
      .restart(restart_v[0]), .addTime(add_v[0]),
      .digit3(dig_all[15:12]), .digit2(dig_all[11:8]),
      .digit1(dig_all[7:4]), .digit0(dig_all[3:0]),
      .running(run_all[0]), .expired(exp_all[0]), .timeUp(tup_all[0]));

   // B: borrow chain from 10:00
   game_timer #(.TICK_DIV(2), .START_MIN(10), .START_SEC(0)) u_b (
      .clk(clk), .rst_n(rstn_v[1]), .start(start_v[1]), .pause(pause_v[1]),
      .restart(restart_v[1]), .addTime(add_v[1]),
      .digit3(dig_all[31:28]), .digit2(dig_all[27:24]),
      .digit1(dig_all[23:20]), .digit0(dig_all[19:16]),
      .running(run_all[1]), .expired(exp_all[1]), .timeUp(tup_all[1]));

   // C: default 03:00 preset, reset mid-count and bonus in PAUSE
   game_timer #(.TICK_DIV(4), .START_MIN(3), .START_SEC(0)) u_c (
      .clk(clk), .rst_n(rstn_v[2]), .start(start_v[2]), .pause(pause_v[2]),
      .restart(restart_v[2]), .addTime(add_v[2]),
      .digit3(dig_all[47:44]), .digit2(dig_all[43:40]),
      .digit1(dig_all[39:36]), .digit0(dig_all[35:32]),
      .running(run_all[2]), .expired(exp_all[2]), .timeUp(tup_all[2]));

   // D: 99:55 preset for saturation
   game_timer #(.TICK_DIV(4), .START_MIN(99), .START_SEC(55)) u_d (
      .clk(clk), .rst_n(rstn_v[3]), .start(start_v[3]), .pause(pause_v[3]),
      .restart(restart_v[3]), .addTime(add_v[3]),
      .digit3(dig_all[63:60]), .digit2(dig_all[59:56]),
      .digit1(dig_all[55:52]), .digit0(dig_all[51:48]),
      .running(run_all[3]), .expired(exp_all[3]), .timeUp(tup_all[3]));

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] dig(input int k);
      return dig_all[16*k +: 16];
   endfunction

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // One-cycle pulse on instance k; ev = {restart, addTime, pause, start}.
   task automatic pulse(input int k, input logic [3:0] ev);
      @(negedge clk);
      start_v[k]   = ev[0];
      pause_v[k]   = ev[1];
      add_v[k]     = ev[2];
      restart_v[k] = ev[3];
      @(negedge clk);
      start_v[k]   = 1'b0;
      pause_v[k]   = 1'b0;
      add_v[k]     = 1'b0;
      restart_v[k] = 1'b0;
   endtask

   localparam logic [3:0] EV_START   = 4'b0001;
   localparam logic [3:0] EV_PAUSE   = 4'b0010;
   localparam logic [3:0] EV_ADD     = 4'b0100;
   localparam logic [3:0] EV_RESTART = 4'b1000;

   initial begin
      checks    = 0;
      failures  = 0;
      rstn_v    = 4'h0;
      start_v   = 4'h0;
      pause_v   = 4'h0;
      restart_v = 4'h0;
      add_v     = 4'h0;
      cyc(2);
      check("rst_a_dig", dig(0), 16'h0003);
      check("rst_c_dig", dig(2), 16'h0300);
      check("rst_run", {12'h0, run_all}, 16'h0000);
      check("rst_exp", {12'h0, exp_all}, 16'h0000);
      check("rst_tup", {12'h0, tup_all}, 16'h0000);
      rstn_v = 4'hF;
      cyc(1);

      // ---- A: countdown to expiry ----
      pulse(0, EV_START);
      check("a_run_after_start", {15'h0, run_all[0]}, 16'h1);
      cyc(3);
      check("a_before_tick1", dig(0), 16'h0003);
      cyc(1);
      check("a_tick1", dig(0), 16'h0002);
      cyc(4);
      check("a_tick2", dig(0), 16'h0001);
      cyc(3);
      check("a_tup_before_end", {15'h0, tup_all[0]}, 16'h0);
      cyc(1);
      check("a_end_dig", dig(0), 16'hDECF);
      check("a_end_exp", {15'h0, exp_all[0]}, 16'h1);
      check("a_end_run", {15'h0, run_all[0]}, 16'h0);
      check("a_end_tup", {15'h0, tup_all[0]}, 16'h1);
      cyc(1);
      check("a_tup_one_cycle", {15'h0, tup_all[0]}, 16'h0);
      check("a_exp_held", {15'h0, exp_all[0]}, 16'h1);
      pulse(0, EV_START | EV_PAUSE | EV_ADD);
      check("a_done_ignores_dig", dig(0), 16'hDECF);
      check("a_done_ignores_exp", {15'h0, exp_all[0]}, 16'h1);
      check("a_done_no_tup", {15'h0, tup_all[0]}, 16'h0);
      pulse(0, EV_RESTART);
      check("a_restart_dig", dig(0), 16'h0003);
      check("a_restart_exp", {15'h0, exp_all[0]}, 16'h0);

      // ---- A: pause retention ----
      pulse(0, EV_START);
      pulse(0, EV_PAUSE);
      check("a_paused_run", {15'h0, run_all[0]}, 16'h0);
      cyc(20);
      check("a_paused_frozen", dig(0), 16'h0003);
      pulse(0, EV_START);
      check("a_resume_run", {15'h0, run_all[0]}, 16'h1);
      cyc(1);
      check("a_resume_plus1", dig(0), 16'h0003);
      cyc(1);
      check("a_resume_plus2", dig(0), 16'h0002);

      // ---- A: bonus coinciding with the tick at 00:01 ----
      cyc(4);
      check("a_at_0001", dig(0), 16'h0001);
      cyc(2);
      pulse(0, EV_ADD);
      check("a_add_tick_dig", dig(0), 16'h0010);
      check("a_add_tick_run", {15'h0, run_all[0]}, 16'h1);
      check("a_add_tick_tup", {15'h0, tup_all[0]}, 16'h0);
      cyc(1);
      check("a_add_tick_tup2", {15'h0, tup_all[0]}, 16'h0);

      // ---- A: priority ----
      pulse(0, EV_RESTART | EV_PAUSE | EV_START);
      check("a_prio_run_dig", dig(0), 16'h0003);
      check("a_prio_run_state", {15'h0, run_all[0]}, 16'h0);
      pulse(0, EV_PAUSE | EV_START);
      check("a_prio_idle_run", {15'h0, run_all[0]}, 16'h1);
      pulse(0, EV_RESTART);

      // ---- B: borrow chain ----
      check("b_preset", dig(1), 16'h1000);
      pulse(1, EV_START);
      cyc(2);
      check("b_borrow", dig(1), 16'h0959);
      pulse(1, EV_RESTART);
      check("b_restart_dig", dig(1), 16'h1000);
      check("b_restart_run", {15'h0, run_all[1]}, 16'h0);

      // ---- C: asynchronous reset mid-count ----
      pulse(2, EV_START);
      cyc(172);
      check("c_at_0217", dig(2), 16'h0217);
      rstn_v[2] = 1'b0;
      #1;
      check("c_async_dig", dig(2), 16'h0300);
      check("c_async_run", {15'h0, run_all[2]}, 16'h0);
      @(negedge clk);
      rstn_v[2] = 1'b1;
      cyc(10);
      check("c_no_restart_dig", dig(2), 16'h0300);
      check("c_no_restart_run", {15'h0, run_all[2]}, 16'h0);

      // ---- C: pause coinciding with tick, then bonus at 00:55 ----
      pulse(2, EV_START);
      cyc(498);
      pulse(2, EV_PAUSE);
      check("c_pause_tick_dig", dig(2), 16'h0055);
      check("c_pause_tick_run", {15'h0, run_all[2]}, 16'h0);
      cyc(8);
      check("c_pause_frozen", dig(2), 16'h0055);
      pulse(2, EV_ADD);
      check("c_add_pause", dig(2), 16'h0105);
      check("c_add_pause_run", {15'h0, run_all[2]}, 16'h0);

      // ---- D: saturation ----
      pulse(3, EV_ADD);
      check("d_add_idle_ignored", dig(3), 16'h9955);
      pulse(3, EV_START);
      pulse(3, EV_ADD);
      check("d_add_sat", dig(3), 16'h9959);
      cyc(1);
      check("d_sat_hold", dig(3), 16'h9959);
      cyc(1);
      check("d_tick_after_sat", dig(3), 16'h9958);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/game_timer.md
# game_timer

Countdown game timer that produces the four 4-bit digit codes consumed directly by the per-digit seven-segment decoders on the board display.
- Counts a preset MM:SS down to 00:00 at one step per second, derived from the system clock.
- Supports start, pause/resume, bonus-time add and restart.
- On expiry, shows "End" using the decoder's letter codes and pulses a flag to the game controller.

## Interface
Parameters:
- TICK_DIV, 50_000_000: clock cycles per one-second step; legal range ≥ 2.
- START_MIN, 3: preset minutes; legal range 0..99.
- START_SEC, 0: preset seconds; legal range 0..59. The preset must not be 00:00.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst_n  in  1  reset; one clock, reset asynchronous, active-low.
- start  in  1  one-cycle pulse; begins or resumes counting.
- pause  in  1  one-cycle pulse; toggles between running and paused.
- restart  in  1  one-cycle pulse; reload preset and return to idle.
- addTime  in  1  one-cycle pulse; add 10 s bonus.
- digit3  out  4  minutes-tens code.
- digit2  out  4  minutes-ones code.
- digit1  out  4  seconds-tens code.
- digit0  out  4  seconds-ones code.
- running  out  1  high while in RUN.
- expired  out  1  high while in DONE.
- timeUp  out  1  one-cycle pulse on the first cycle in DONE.

## Operation
- Time is held as four BCD registers: mT (0..9), mO (0..9), sT (0..5), sO (0..9).
- States:
  - IDLE: time = preset, prescaler = 0.
  - RUN: counting.
  - PAUSE: time and prescaler frozen.
  - DONE: terminal until restart.
- Transitions, with restart > pause > start priority in every state:
  - Any state, restart → IDLE; reload preset; clear prescaler.
  - IDLE, start → RUN; clear prescaler. pause is ignored in IDLE.
  - RUN, pause → PAUSE.
  - PAUSE, pause or start → RUN; prescaler resumes from its held value.
  - RUN, a tick that yields 00:00 → DONE.
  - DONE: start, pause and addTime are ignored.
- Prescaler counts 0..TICK_DIV-1 in RUN only. A tick is the cycle in which prescaler == TICK_DIV-1; on that edge the prescaler wraps to 0 and time decrements by 1 s.
- BCD decrement borrows as follows:
  - sO 0 → 9 with a borrow into sT.
  - sT 0 → 5 with a borrow into mO.
  - mO 0 → 9 with a borrow into mT.
- addTime is effective in RUN and PAUSE only. It adds 10 s: sT+1, with sT 5 → 0 carrying into minutes. The result saturates at 99:59.
- If addTime and a tick occur in the same cycle, the net change is +9 s, saturating at 99:59. Expiry is evaluated on the net result, so 00:01 with both events → 00:10 and the timer stays in RUN.
- If pause and a tick occur in the same cycle, the decrement is applied and the state becomes PAUSE. If that decrement reaches 00:00, the state becomes DONE and pause is dropped.
- Display in IDLE, RUN and PAUSE: digit3..0 = mT, mO, sT, sO.
- Display in DONE: digit3 = 13 (E), digit2 = 14 (n), digit1 = 12 (d), digit0 = 15 (blank).
- Codes 10 and 11 are never emitted.

## Timing
- Reset, asynchronous on rst_n low:
  - State IDLE; time = preset; prescaler 0.
  - running 0, expired 0, timeUp 0.
  - Digits show the preset, e.g. 0,3,0,0 for the defaults.
- Digits, running and expired are combinational decodes of registered state, so they change in the same cycle as the state or time register. There is no added latency.
- Timing from a start pulse sampled at edge N:
  - running is high after edge N.
  - The first decrement occurs at edge N+TICK_DIV.
  - Subsequent decrements follow every TICK_DIV cycles.
- Pause and resume lose no partial-second progress: the prescaler is held, not cleared.
- On the expiring tick edge E:
  - expired goes high and running goes low after E.
  - timeUp is high for exactly the cycle between E and E+1.
- restart in DONE: expired drops after the next edge. timeUp is never reasserted without a new expiry.
- If rst_n is asserted mid-RUN, the block returns immediately to the reset values. Counting does not resume until a new start pulse.

## Test plan
- With TICK_DIV=4, START_MIN=0, START_SEC=3: release reset, then pulse start. Digits step 0,0,0,3 → 0,0,0,2 → 0,0,0,1 every 4 cycles. On the next tick the display shows 13,14,12,15, expired=1, and timeUp is high for exactly 1 cycle.
- Borrow chain: with the preset at 10:00 and TICK_DIV=2, one tick gives 0,9,5,9. Then apply restart and check the digits return to 1,0,0,0 with running=0.
- Pause retention: with TICK_DIV=4, pulse pause 2 cycles after start, hold 20 cycles, then pulse start. The first decrement arrives exactly 2 cycles after resume.
- addTime:
  - At 00:55 in PAUSE → 01:05.
  - At 99:55 → 99:59 (saturated).
  - At 00:01 coinciding with a tick → 00:10, no timeUp.
- Priority: restart, pause and start in the same cycle while in RUN → IDLE with the preset displayed. start and pause in the same cycle in IDLE → RUN.
- Asynchronous reset mid-count at 02:17: digits show 0,3,0,0 before the next clock edge, and a start pulse is required before counting resumes.
